arith_result_framer: RTL and testbench
======================================

Name: arith_result_framer

Overview:
- Downstream stage of the registered arithmetic unit.
- Captures each 32-bit result plus its carry into a small FIFO, then serializes it as a 6-byte frame on a byte-wide valid/ready stream (e.g. toward a UART TX or a debug port).
- Absorbs bursts from the arithmetic unit, which has no backpressure.
- Counts any results dropped because the FIFO was full.

Parameters:
- IN_DATA_WIDTH, 32, result width; must be a multiple of 8.
- FIFO_DEPTH, 4, result-FIFO entries; must be a power of 2 and at least 2.
- HEADER_BYTE, 8'hA5, first byte of every frame.

Ports:
- CLK  input  1  clock; all logic on its rising edge.
- RST  input  1  synchronous, active-high reset.
- IN_DATA  input  IN_DATA_WIDTH  result word, aligned with IN_VALID (the integrator drives it from Arith_OUT).
- IN_CARRY  input  1  carry bit, aligned with IN_VALID.
- IN_VALID  input  1  one-cycle pulse per result, aligned with the registered result (the arithmetic flag delayed by one cycle).
- CLR_OVF  input  1  pulse; clears OVERFLOW and DROP_CNT.
- TX_READY  input  1  downstream accepts the byte when TX_VALID and TX_READY are both high.
- TX_DATA  output  8  current frame byte.
- TX_VALID  output  1  TX_DATA is valid.
- TX_LAST  output  1  high with the final byte of a frame.
- BUSY  output  1  high when the FIFO is non-empty or a frame is in flight.
- OVERFLOW  output  1  sticky flag; set when a result is dropped.
- DROP_CNT  output  8  count of dropped results; saturates at 255.

Behaviour:
- Reset (RST=1 at a clock edge):
  - FIFO emptied; state returns to IDLE.
  - TX_VALID=0, TX_LAST=0, TX_DATA=0, BUSY=0, OVERFLOW=0, DROP_CNT=0.
  - A reset mid-frame aborts the frame; no partial bytes follow it.
- Frame format, 6 bytes for the default width, in order:
  - byte0 = HEADER_BYTE.
  - bytes 1..IN_DATA_WIDTH/8 = result, MSB first.
  - final byte = {7'b0, carry}.
- FIFO push:
  - Accepted when IN_VALID=1 and (not full, or a pop occurs in the same cycle).
  - Otherwise the result is dropped: OVERFLOW<=1 and DROP_CNT increments (saturating).
  - If CLR_OVF and a drop coincide, the drop wins: OVERFLOW=1, DROP_CNT=1.
- State machine, IDLE / SEND:
  - IDLE: when the FIFO is non-empty, pop the head into the frame shift register, byte index=0, go to SEND. TX_VALID rises on the next cycle, so first byte latency from an IN_VALID into an empty idle block is 2 cycles.
  - SEND: TX_VALID=1. TX_DATA and TX_LAST hold stable while TX_READY=0.
  - On each handshake, advance the byte index.
  - On the handshake of the last byte: if the FIFO is non-empty, pop the next entry in the same cycle and stay in SEND. The next frame's header appears the following cycle with no idle gap.
  - On the last-byte handshake with an empty FIFO: go to IDLE, and TX_VALID=0 the next cycle.
- TX_VALID never drops without a handshake, except on reset.
- Push into an empty FIFO while in IDLE: the pop happens the cycle after the push (no bypass).
- FIFO pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished with an extra pointer bit.
- BUSY = (FIFO non-empty) OR (state == SEND).

Test Plan:
- Single result: IN_DATA=32'h1234_5678, IN_CARRY=1, TX_READY=1 throughout -> TX_DATA sequence A5,12,34,56,78,01, with TX_VALID starting 2 cycles after IN_VALID, TX_LAST on the 01 byte only, and BUSY low afterward.
- Backpressure: same input, TX_READY toggled 1,0,0,1,... -> every byte is held stable while not ready, no byte is lost or duplicated, and the sequence is unchanged.
- Back-to-back: two results 32'hFFFF_FFFF (carry 0) then 32'h0000_0001 (carry 1) on consecutive cycles, TX_READY=1 -> 12 contiguous TX_VALID cycles: A5,FF,FF,FF,FF,00,A5,00,00,00,01,01.
- Overflow: TX_READY=0, six consecutive IN_VALID pulses with FIFO_DEPTH=4 -> the first pulse is popped into the frame register, the next 4 fill the FIFO, the sixth is dropped, giving OVERFLOW=1 and DROP_CNT=1. CLR_OVF -> OVERFLOW=0, DROP_CNT=0. Release TX_READY -> exactly 5 complete frames.
- Push while full with simultaneous pop: FIFO full, IN_VALID coincides with the last-byte handshake -> push accepted, no drop, and DROP_CNT unchanged.
- Reset mid-frame: RST=1 after byte 2 has been handshaked -> next cycle TX_VALID=0, BUSY=0, and the next valid result produces a clean frame beginning with A5.

Source files
------------

// File: rtl/arith_result_framer_if.sv
// Result-in / byte-out stream bundle for arith_result_framer; master drives results and TX_READY.
interface arith_result_framer_if #(
  parameter int IN_DATA_WIDTH = 32
);
  logic [IN_DATA_WIDTH-1:0] IN_DATA;
  logic                     IN_CARRY;
  logic                     IN_VALID;
  logic                     TX_READY;
  logic [7:0]               TX_DATA;
  logic                     TX_VALID;
  logic                     TX_LAST;

  modport master (
    output IN_DATA, IN_CARRY, IN_VALID, TX_READY,
    input  TX_DATA, TX_VALID, TX_LAST
  );

  modport slave (
    input  IN_DATA, IN_CARRY, IN_VALID, TX_READY,
    output TX_DATA, TX_VALID, TX_LAST
  );
endinterface

// File: rtl/arith_result_framer.sv
// Buffers {carry,result} in a FIFO and emits header/result(MSB first)/carry byte frames; first byte 2 cycles after IN_VALID.
// TX stalls hold TX_DATA/TX_LAST; the input side has no backpressure, so results arriving while full are dropped and counted.
module arith_result_framer #(
  parameter int         IN_DATA_WIDTH = 32,
  parameter int         FIFO_DEPTH    = 4,
  parameter logic [7:0] HEADER_BYTE   = 8'hA5
) (
  input  logic                  CLK,
  input  logic                  RST,
  arith_result_framer_if.slave  bus,
  input  logic                  CLR_OVF,
  output logic                  BUSY,
  output logic                  OVERFLOW,
  output logic [7:0]            DROP_CNT
);
  localparam int NBYTES = IN_DATA_WIDTH / 8 + 2;
  localparam int FW     = 8 * NBYTES;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int IW     = $clog2(NBYTES);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                 state_q, state_d;
  logic [IN_DATA_WIDTH:0] fifo_mem [FIFO_DEPTH];
  logic [AW:0]            wr_ptr, rd_ptr;
  logic [FW-1:0]          frame_sr;
  logic [IW-1:0]          byte_idx;
  logic                   fifo_empty, fifo_full, last_byte, tx_hs;
  logic                   push, pop, drop;
  logic [IN_DATA_WIDTH:0] head;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head       = fifo_mem[rd_ptr[AW-1:0]];
  assign last_byte  = (byte_idx == IW'(NBYTES - 1));
  assign tx_hs      = bus.TX_VALID && bus.TX_READY;

  // A pop only ever comes from a non-empty FIFO, so there is no push-to-pop bypass.
  assign pop  = !fifo_empty && ((state_q == IDLE) || (tx_hs && last_byte));
  assign push = bus.IN_VALID && (!fifo_full || pop);
  assign drop = bus.IN_VALID && !push;

  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_mem[wr_ptr[AW-1:0]] <= {bus.IN_CARRY, bus.IN_DATA};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      frame_sr <= '0;
      byte_idx <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + (AW+1)'(1);
        frame_sr <= {HEADER_BYTE, head[IN_DATA_WIDTH-1:0], 7'b0, head[IN_DATA_WIDTH]};
        byte_idx <= '0;
      end else if (tx_hs) begin
        // Zero fill leaves TX_DATA at 0 once a frame has fully drained.
        frame_sr <= {frame_sr[FW-9:0], 8'h00};
        byte_idx <= byte_idx + IW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      OVERFLOW <= 1'b0;
      DROP_CNT <= 8'd0;
    end else if (drop) begin
      OVERFLOW <= 1'b1;
      DROP_CNT <= CLR_OVF ? 8'd1 : ((DROP_CNT == 8'hFF) ? DROP_CNT : DROP_CNT + 8'd1);
    end else if (CLR_OVF) begin
      OVERFLOW <= 1'b0;
      DROP_CNT <= 8'd0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifo_empty) state_d = SEND;
      SEND:    if (tx_hs && last_byte && fifo_empty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.TX_VALID = (state_q == SEND);
    bus.TX_LAST  = (state_q == SEND) && last_byte;
    bus.TX_DATA  = frame_sr[FW-1 -: 8];
    BUSY         = !fifo_empty || (state_q == SEND);
  end
endmodule

// File: tb/tb_arith_result_framer.sv
// Directed bench for arith_result_framer with a byte scoreboard fed at stimulus time.
module tb_arith_result_framer;
  logic       CLK = 1'b0;
  logic       RST;
  logic       CLR_OVF;
  logic       BUSY;
  logic       OVERFLOW;
  logic [7:0] DROP_CNT;

  arith_result_framer_if #(.IN_DATA_WIDTH(32)) bus ();

  arith_result_framer #(
    .IN_DATA_WIDTH(32),
    .FIFO_DEPTH   (4),
    .HEADER_BYTE  (8'hA5)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .bus     (bus),
    .CLR_OVF (CLR_OVF),
    .BUSY    (BUSY),
    .OVERFLOW(OVERFLOW),
    .DROP_CNT(DROP_CNT)
  );

  always #5 CLK = ~CLK;

  int         vectors = 0;
  int         miscompares = 0;
  logic [8:0] sb[$];
  logic [8:0] sb_head;
  int         mon_bytes = 0;
  int         mon_frames = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void push_frame(input logic [31:0] d, input logic c);
    sb.push_back({1'b0, 8'hA5});
    for (int b = 3; b >= 0; b--) sb.push_back({1'b0, d[b*8 +: 8]});
    sb.push_back({1'b1, 7'b0, c});
  endfunction

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic c, input bit accept);
    bus.IN_DATA  = d;
    bus.IN_CARRY = c;
    bus.IN_VALID = 1'b1;
    if (accept) push_frame(d, c);
    cyc();
    bus.IN_VALID = 1'b0;
  endtask

  // bp=1 drives TX_READY with the repeating pattern 1,0,0,1.
  task automatic drain(input int budget, input bit bp);
    int i = 0;
    while ((BUSY !== 1'b0 || sb.size() != 0) && i < budget) begin
      bus.TX_READY = bp ? ((i % 4 == 0) || (i % 4 == 3)) : 1'b1;
      cyc();
      i++;
    end
    bus.TX_READY = 1'b1;
    @(negedge CLK);
    chk("drain_busy", BUSY, 0);
    chk("drain_sb_empty", sb.size(), 0);
  endtask

  // Output monitor: every handshaked byte is popped from the scoreboard; stalls must hold.
  always @(negedge CLK) begin
    if (RST !== 1'b0) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", bus.TX_VALID, 1);
        chk("hold_data", bus.TX_DATA, prev_data);
        chk("hold_last", bus.TX_LAST, prev_last);
      end
      if (bus.TX_VALID === 1'b1 && bus.TX_READY === 1'b1) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $error("FAIL unexpected_byte: got %0h expected no byte", bus.TX_DATA);
        end else begin
          sb_head = sb.pop_front();
          chk("tx_byte", bus.TX_DATA, sb_head[7:0]);
          chk("tx_last", bus.TX_LAST, sb_head[8]);
          mon_bytes++;
          if (bus.TX_LAST === 1'b1) mon_frames++;
        end
      end
      prev_stall = (bus.TX_VALID === 1'b1) && (bus.TX_READY !== 1'b1);
      prev_data  = bus.TX_DATA;
      prev_last  = bus.TX_LAST;
    end
  end

  initial begin
    int f0;
    int b0;
    int run;
    int i;
    bit found;

    RST          = 1'b1;
    CLR_OVF      = 1'b0;
    bus.IN_DATA  = '0;
    bus.IN_CARRY = 1'b0;
    bus.IN_VALID = 1'b0;
    bus.TX_READY = 1'b1;
    repeat (3) cyc();
    @(negedge CLK);
    chk("rst_tx_valid", bus.TX_VALID, 0);
    chk("rst_tx_last", bus.TX_LAST, 0);
    chk("rst_tx_data", bus.TX_DATA, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_overflow", OVERFLOW, 0);
    chk("rst_drop_cnt", DROP_CNT, 0);
    cyc();
    RST = 1'b0;
    cyc();

    // Single result: TX_VALID low one edge after the push, high after the second.
    f0 = mon_frames;
    send(32'h1234_5678, 1'b1, 1'b1);
    @(negedge CLK);
    chk("lat_not_yet_valid", bus.TX_VALID, 0);
    chk("lat_busy", BUSY, 1);
    cyc();
    @(negedge CLK);
    chk("lat_valid_2cyc", bus.TX_VALID, 1);
    chk("lat_first_byte", bus.TX_DATA, 8'hA5);
    drain(50, 1'b0);
    chk("single_frames", mon_frames - f0, 1);
    chk("single_tx_data_idle", bus.TX_DATA, 0);

    // Backpressure with the 1,0,0,1 ready pattern.
    cyc();
    f0 = mon_frames;
    send(32'h1234_5678, 1'b1, 1'b1);
    drain(200, 1'b1);
    chk("bp_frames", mon_frames - f0, 1);

    // Back-to-back results give 12 contiguous valid cycles.
    cyc();
    f0 = mon_frames;
    send(32'hFFFF_FFFF, 1'b0, 1'b1);
    send(32'h0000_0001, 1'b1, 1'b1);
    run = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge CLK);
      if (bus.TX_VALID === 1'b1) run++;
      else if (run > 0) break;
    end
    chk("b2b_run_len", run, 12);
    cyc();
    drain(50, 1'b0);
    chk("b2b_frames", mon_frames - f0, 2);

    // Overflow: one result in the frame register, four in the FIFO, sixth dropped.
    cyc();
    f0 = mon_frames;
    bus.TX_READY = 1'b0;
    for (int k = 0; k < 6; k++) send(32'hA000_0000 + k, k[0], k < 5);
    @(negedge CLK);
    chk("ovf_flag", OVERFLOW, 1);
    chk("ovf_drop_cnt", DROP_CNT, 1);
    chk("ovf_busy", BUSY, 1);
    cyc();
    send(32'hDEAD_0006, 1'b0, 1'b0);
    @(negedge CLK);
    chk("ovf_drop_cnt2", DROP_CNT, 2);
    cyc();
    CLR_OVF = 1'b1;
    send(32'hDEAD_0007, 1'b1, 1'b0);
    CLR_OVF = 1'b0;
    @(negedge CLK);
    chk("clr_drop_wins_flag", OVERFLOW, 1);
    chk("clr_drop_wins_cnt", DROP_CNT, 1);
    cyc();
    CLR_OVF = 1'b1;
    cyc();
    CLR_OVF = 1'b0;
    @(negedge CLK);
    chk("clr_flag", OVERFLOW, 0);
    chk("clr_cnt", DROP_CNT, 0);
    cyc();
    drain(300, 1'b0);
    chk("ovf_frames", mon_frames - f0, 5);

    // Full FIFO: a push coinciding with the last-byte handshake is accepted.
    cyc();
    f0 = mon_frames;
    bus.TX_READY = 1'b0;
    for (int k = 0; k < 5; k++) send(32'hB000_0000 + k, ~k[0], 1'b1);
    bus.TX_READY = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (bus.TX_VALID === 1'b1 && bus.TX_LAST === 1'b1) begin
        found = 1'b1;
        break;
      end
      cyc();
    end
    chk("full_pop_reached_last", found, 1);
    send(32'hC0DE_0005, 1'b1, 1'b1);
    @(negedge CLK);
    chk("full_pop_no_ovf", OVERFLOW, 0);
    chk("full_pop_drop_cnt", DROP_CNT, 0);
    cyc();
    drain(300, 1'b0);
    chk("full_pop_frames", mon_frames - f0, 6);

    // Reset after byte 2 handshakes: frame aborted, next frame clean.
    cyc();
    b0 = mon_bytes;
    send(32'hCAFE_BABE, 1'b0, 1'b1);
    i = 0;
    while (mon_bytes < b0 + 3 && i < 20) begin
      cyc();
      i++;
    end
    chk("rst_mid_bytes_seen", mon_bytes - b0, 3);
    RST = 1'b1;
    sb.delete();
    cyc();
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_mid_tx_valid", bus.TX_VALID, 0);
    chk("rst_mid_busy", BUSY, 0);
    chk("rst_mid_tx_data", bus.TX_DATA, 0);
    cyc();
    f0 = mon_frames;
    send(32'h5A5A_0F0F, 1'b1, 1'b1);
    drain(50, 1'b0);
    chk("rst_mid_clean_frame", mon_frames - f0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
